// File: rtl/tlc_conflict_monitor_if.sv
// Lamp-drive / fault-report bundle between the traffic light controller side
// and the conflict monitor.
//   mr_g/mr_y/mr_r  main road lamp drives (master -> slave)
//   sr_g/sr_y/sr_r  side road lamp drives (master -> slave)
//   fault_clr       operator clear pulse  (master -> slave)
//   fault           fault latched         (slave -> master)
//   fault_code      3-bit fault class     (slave -> master)
//   fault_road      0 main, 1 side        (slave -> master)
//   flash_out       red-flash request     (slave -> master)
interface tlc_conflict_monitor_if;
  logic       mr_g;
  logic       mr_y;
  logic       mr_r;
  logic       sr_g;
  logic       sr_y;
  logic       sr_r;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_road;
  logic       flash_out;

  modport master (
    output mr_g, mr_y, mr_r, sr_g, sr_y, sr_r, fault_clr,
    input  fault, fault_code, fault_road, flash_out
  );

  modport slave (
    input  mr_g, mr_y, mr_r, sr_g, sr_y, sr_r, fault_clr,
    output fault, fault_code, fault_road, flash_out
  );
endinterface

// File: rtl/tlc_conflict_monitor.sv
// Independent safety monitor for the traffic light controller. Registers the
// six lamp drives, tracks per-road aspect and dwell, and latches the first
// fault (bad lamp combination, conflicting roads, illegal sequence, short
// green/yellow). A latched fault requests red-flash until the operator clears
// it and the intersection has been seen all-red for MIN_RED_CLR cycles.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   mon  slave side of tlc_conflict_monitor_if (lamp inputs, fault_clr in;
//        fault, fault_code, fault_road, flash_out out; all outputs registered)
module tlc_conflict_monitor #(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MIN_YELLOW  = 3,
  parameter int unsigned MIN_RED_CLR = 2,
  parameter int unsigned FLASH_HALF  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  tlc_conflict_monitor_if.slave  mon
);

  localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int unsigned RED_W   = $clog2(MIN_RED_CLR + 1);
  localparam int unsigned NROAD   = 2;

  typedef enum logic [1:0] {
    ASP_R   = 2'd0,
    ASP_G   = 2'd1,
    ASP_Y   = 2'd2,
    ASP_INV = 2'd3
  } aspect_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_LAMP     = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_SEQ      = 3'd3,
    FC_SHORT_G  = 3'd4,
    FC_SHORT_Y  = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  // Lamp triple is {g, y, r}; exactly one lit is a valid aspect.
  function automatic aspect_e decode(input logic [2:0] lamps);
    case (lamps)
      3'b100:  return ASP_G;
      3'b010:  return ASP_Y;
      3'b001:  return ASP_R;
      default: return ASP_INV;
    endcase
  endfunction

  // Index 0 = main road, 1 = side road.
  logic [2:0]         lamp_q  [NROAD];
  logic [2:0]         lamp_d  [NROAD];
  aspect_e            asp_q   [NROAD];
  aspect_e            asp_d   [NROAD];
  logic [CNT_W-1:0]   dwell_q [NROAD];
  logic [CNT_W-1:0]   dwell_d [NROAD];

  state_e             state_q, state_d;
  logic               fault_q, fault_d;
  fault_code_e        code_q, code_d;
  logic               road_q, road_d;
  logic               flash_q, flash_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [RED_W-1:0]   red_cnt_q, red_cnt_d;

  aspect_e            cur_c [NROAD];
  logic [NROAD-1:0]   lamp_bad_c;
  logic [NROAD-1:0]   moved_c;
  logic [NROAD-1:0]   seq_bad_c;
  logic [NROAD-1:0]   short_g_c;
  logic [NROAD-1:0]   short_y_c;
  logic               conflict_c;
  logic               all_red_c;
  logic               hit_c;
  fault_code_e        hit_code_c;
  logic               hit_road_c;

  // Input stage: sample lamp drives once per cycle.
  always_comb begin : sample_next
    lamp_d[0] = {mon.mr_g, mon.mr_y, mon.mr_r};
    lamp_d[1] = {mon.sr_g, mon.sr_y, mon.sr_r};
  end

  // Decode sampled lamps and evaluate every check against the tracker.
  always_comb begin : checks
    lamp_bad_c = '0;
    moved_c    = '0;
    seq_bad_c  = '0;
    short_g_c  = '0;
    short_y_c  = '0;
    for (int r = 0; r < NROAD; r++) begin
      cur_c[r]      = decode(lamp_q[r]);
      lamp_bad_c[r] = (cur_c[r] == ASP_INV);
      moved_c[r]    = !lamp_bad_c[r] && (cur_c[r] != asp_q[r]);
      seq_bad_c[r]  = moved_c[r] &&
                      (((asp_q[r] == ASP_G) && (cur_c[r] == ASP_R)) ||
                       ((asp_q[r] == ASP_Y) && (cur_c[r] == ASP_G)) ||
                       ((asp_q[r] == ASP_R) && (cur_c[r] == ASP_Y)));
      short_g_c[r]  = moved_c[r] && (asp_q[r] == ASP_G) && (cur_c[r] == ASP_Y) &&
                      (dwell_q[r] < CNT_W'(MIN_GREEN));
      short_y_c[r]  = moved_c[r] && (asp_q[r] == ASP_Y) && (cur_c[r] == ASP_R) &&
                      (dwell_q[r] < CNT_W'(MIN_YELLOW));
    end
    conflict_c = ((cur_c[0] == ASP_G) || (cur_c[0] == ASP_Y)) &&
                 ((cur_c[1] == ASP_G) || (cur_c[1] == ASP_Y));
    all_red_c  = (cur_c[0] == ASP_R) && (cur_c[1] == ASP_R);
  end

  // Fault class priority, then main road ahead of side road.
  always_comb begin : priority_enc
    hit_code_c = FC_NONE;
    hit_road_c = 1'b0;
    if (|lamp_bad_c) begin
      hit_code_c = FC_LAMP;
      hit_road_c = !lamp_bad_c[0];
    end else if (conflict_c) begin
      hit_code_c = FC_CONFLICT;
    end else if (|seq_bad_c) begin
      hit_code_c = FC_SEQ;
      hit_road_c = !seq_bad_c[0];
    end else if (|short_g_c) begin
      hit_code_c = FC_SHORT_G;
      hit_road_c = !short_g_c[0];
    end else if (|short_y_c) begin
      hit_code_c = FC_SHORT_Y;
      hit_road_c = !short_y_c[0];
    end
    hit_c = (hit_code_c != FC_NONE);
  end

  // Aspect/dwell tracker; runs in every state, holds on an invalid sample.
  always_comb begin : tracker_next
    for (int r = 0; r < NROAD; r++) begin
      asp_d[r]   = asp_q[r];
      dwell_d[r] = dwell_q[r];
      if (moved_c[r]) begin
        asp_d[r]   = cur_c[r];
        dwell_d[r] = CNT_W'(1);
      end else if (!lamp_bad_c[r] && (dwell_q[r] != {CNT_W{1'b1}})) begin
        dwell_d[r] = dwell_q[r] + CNT_W'(1);
      end
    end
  end

  // Fault latch FSM: next state and registered outputs.
  always_comb begin : fsm_next
    state_d     = state_q;
    fault_d     = fault_q;
    code_d      = code_q;
    road_d      = road_q;
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    red_cnt_d   = red_cnt_q;
    case (state_q)
      ST_MONITOR: begin
        if (hit_c) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          code_d      = hit_code_c;
          road_d      = hit_road_c;
          flash_d     = 1'b1;
          flash_cnt_d = '0;
        end
      end
      ST_FAULT: begin
        if (mon.fault_clr && all_red_c) begin
          state_d     = ST_RECOVER;
          flash_d     = 1'b0;
          flash_cnt_d = '0;
          red_cnt_d   = RED_W'(1);
        end else if (flash_cnt_q == FLASH_W'(FLASH_HALF - 1)) begin
          flash_d     = !flash_q;
          flash_cnt_d = '0;
        end else begin
          flash_cnt_d = flash_cnt_q + FLASH_W'(1);
        end
      end
      ST_RECOVER: begin
        if (!all_red_c) begin
          // Code and road stay frozen; the flash pattern restarts.
          state_d     = ST_FAULT;
          flash_d     = 1'b1;
          flash_cnt_d = '0;
          red_cnt_d   = '0;
        end else if (red_cnt_q >= RED_W'(MIN_RED_CLR - 1)) begin
          state_d   = ST_MONITOR;
          fault_d   = 1'b0;
          code_d    = FC_NONE;
          road_d    = 1'b0;
          red_cnt_d = '0;
        end else begin
          red_cnt_d = red_cnt_q + RED_W'(1);
        end
      end
      default: begin
        state_d = ST_MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      for (int r = 0; r < NROAD; r++) begin
        lamp_q[r]  <= 3'b001;
        asp_q[r]   <= ASP_R;
        dwell_q[r] <= '0;
      end
      state_q     <= ST_MONITOR;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      road_q      <= 1'b0;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
      red_cnt_q   <= '0;
    end else begin
      for (int r = 0; r < NROAD; r++) begin
        lamp_q[r]  <= lamp_d[r];
        asp_q[r]   <= asp_d[r];
        dwell_q[r] <= dwell_d[r];
      end
      state_q     <= state_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      road_q      <= road_d;
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
      red_cnt_q   <= red_cnt_d;
    end
  end

  assign mon.fault      = fault_q;
  assign mon.fault_code = code_q;
  assign mon.fault_road = road_q;
  assign mon.flash_out  = flash_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed bench for tlc_conflict_monitor: legal cycles, each fault class,
// priority, flash pattern, clear/recover paths and reset out of FAULT.
module tb_tlc_conflict_monitor;

  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;
  localparam logic [2:0] LD = 3'b000;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  tlc_conflict_monitor_if bus ();

  tlc_conflict_monitor dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lamps(input logic [2:0] m, input logic [2:0] s);
    {bus.mr_g, bus.mr_y, bus.mr_r} = m;
    {bus.sr_g, bus.sr_y, bus.sr_r} = s;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic f, input logic [2:0] c,
                         input logic rd);
    chk({tag, "_fault"}, 8'(bus.fault), 8'(f));
    chk({tag, "_code"},  8'(bus.fault_code), 8'(c));
    chk({tag, "_road"},  8'(bus.fault_road), 8'(rd));
  endtask

  // Drive all-red, pulse clear, expect RECOVER then MONITOR.
  task automatic recover(input string tag);
    lamps(LR, LR);
    tick();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk({tag, "_rec_fault"}, 8'(bus.fault), 8'd1);
    chk({tag, "_rec_flash"}, 8'(bus.flash_out), 8'd0);
    tick();
    chk_all({tag, "_cleared"}, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    lamps(LR, LR);
    tick(2);
    chk_all("reset", 1'b0, 3'd0, 1'b0);
    chk("reset_flash", 8'(bus.flash_out), 8'd0);
    rst = 1'b0;
    tick();

    // Legal main cycle: R 10, G 4, Y 3, R.
    tick(10);
    lamps(LG, LR); tick(4);
    chk("legal_g_fault", 8'(bus.fault), 8'd0);
    lamps(LY, LR); tick(3);
    chk("legal_y_fault", 8'(bus.fault), 8'd0);
    lamps(LR, LR); tick(3);
    chk_all("legal_cycle", 1'b0, 3'd0, 1'b0);

    // Long green: dwell must saturate, not wrap to a short value.
    lamps(LG, LR); tick(258);
    lamps(LY, LR); tick(3);
    lamps(LR, LR); tick(3);
    chk("sat_dwell_fault", 8'(bus.fault), 8'd0);

    // Clear request in MONITOR does nothing.
    bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0; tick();
    chk("clr_in_monitor_fault", 8'(bus.fault), 8'd0);
    chk("clr_in_monitor_flash", 8'(bus.flash_out), 8'd0);

    // Short green on main; flash 1111 0000 1111.
    lamps(LG, LR); tick(2);
    lamps(LY, LR); tick();
    chk("short_g_lat1_fault", 8'(bus.fault), 8'd0);
    tick();
    chk_all("short_g", 1'b1, 3'd4, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("flash_%0d", i), 8'(bus.flash_out), 8'(((i / 4) % 2) == 0));
      tick();
    end
    recover("short_g");

    // Conflict: side G->Y legally while main R->G.
    lamps(LR, LG); tick(5);
    lamps(LG, LY); tick(2);
    chk_all("conflict", 1'b1, 3'd2, 1'b0);
    lamps(LG, LG); tick(2);
    chk_all("conflict_hold1", 1'b1, 3'd2, 1'b0);
    lamps(LG, LR); tick(2);
    chk_all("conflict_hold2", 1'b1, 3'd2, 1'b0);
    recover("conflict");

    // Dark side road -> LAMP on side.
    lamps(LR, LD); tick(2);
    chk_all("lamp_side", 1'b1, 3'd1, 1'b1);
    chk("lamp_side_flash", 8'(bus.flash_out), 8'd1);
    bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0; tick();
    chk("clr_not_red_fault", 8'(bus.fault), 8'd1);
    chk("clr_not_red_flash", 8'(bus.flash_out), 8'd1);
    // Going all-red later must not act on the stale request.
    lamps(LR, LR); tick(4);
    chk_all("clr_no_memory", 1'b1, 3'd1, 1'b1);

    // Recovery from the LAMP fault.
    bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0;
    chk_all("recover_lamp", 1'b1, 3'd1, 1'b1);
    chk("recover_lamp_flash", 8'(bus.flash_out), 8'd0);
    tick();
    chk_all("recover_lamp_done", 1'b0, 3'd0, 1'b0);

    // Main G->R -> SEQ; recovery aborted by main G in the second cycle.
    lamps(LG, LR); tick(5);
    lamps(LR, LR); tick(2);
    chk_all("seq", 1'b1, 3'd3, 1'b0);
    bus.fault_clr = 1'b1;
    lamps(LG, LR);
    tick();
    bus.fault_clr = 1'b0;
    chk("abort_rec_fault", 8'(bus.fault), 8'd1);
    chk("abort_rec_flash", 8'(bus.flash_out), 8'd0);
    tick();
    chk_all("abort_back_fault", 1'b1, 3'd3, 1'b0);
    chk("abort_flash_restart", 8'(bus.flash_out), 8'd1);

    // Reset while in FAULT.
    rst = 1'b1; tick();
    chk_all("rst_in_fault", 1'b0, 3'd0, 1'b0);
    chk("rst_in_fault_flash", 8'(bus.flash_out), 8'd0);
    lamps(LR, LR);
    rst = 1'b0; tick(2);
    chk("post_rst_fault", 8'(bus.fault), 8'd0);

    // Short yellow on main.
    lamps(LG, LR); tick(5);
    lamps(LY, LR); tick();
    lamps(LR, LR); tick();
    chk("short_y_lat1_fault", 8'(bus.fault), 8'd0);
    tick();
    chk_all("short_y", 1'b1, 3'd5, 1'b0);
    recover("short_y");

    // Both roads dark: main reported first.
    lamps(LD, LD); tick(2);
    chk_all("lamp_both", 1'b1, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
